// File: rtl/mx_int_block_addsub_pipe_pkg.sv
// Shared constants, shift clamp helper and stage flag type for the MX integer block adder.
package mx_int_pkg;

  localparam int E8M0_BIAS       = 127;
  localparam int DEF_BLOCK_SIZE  = 32;
  localparam int DEF_ELEM_WIDTH  = 8;
  localparam int DEF_SCALE_WIDTH = 8;
  localparam logic [DEF_SCALE_WIDTH-1:0] NAN_SCALE = '1;

  // Saturates a (possibly negative) shift request into [0, max_amt].
  function automatic int clamp_shift(input int amt, input int max_amt);
    if (amt < 0)
      return 0;
    else if (amt > max_amt)
      return max_amt;
    else
      return amt;
  endfunction

  // Per-stage control carried alongside the width-parametrised scale and element payload.
  typedef struct packed {
    logic valid;
    logic nan;
    logic sub;
  } stage_flags_t;

endpackage

// File: rtl/mx_int_block_addsub_pipe_if.sv
// Transaction bundle for the MX block adder: input pair, output block, valid/ready both ways.
interface mx_int_block_addsub_pipe_if #(
  parameter int BLOCK_SIZE  = 32,
  parameter int ELEM_WIDTH  = 8,
  parameter int SCALE_WIDTH = 8
);
  logic                   i_valid;
  logic                   o_ready;
  logic                   i_sub;
  logic [SCALE_WIDTH-1:0] i_scale_a;
  logic [SCALE_WIDTH-1:0] i_scale_b;
  logic [ELEM_WIDTH-1:0]  i_elements_a [BLOCK_SIZE];
  logic [ELEM_WIDTH-1:0]  i_elements_b [BLOCK_SIZE];
  logic                   o_valid;
  logic                   i_ready;
  logic [SCALE_WIDTH-1:0] o_scale;
  logic [ELEM_WIDTH-1:0]  o_elements [BLOCK_SIZE];
  logic                   o_overflow;
  logic                   o_nan;

  modport slave (
    input  i_valid, i_sub, i_scale_a, i_scale_b, i_elements_a, i_elements_b, i_ready,
    output o_ready, o_valid, o_scale, o_elements, o_overflow, o_nan
  );

  modport master (
    output i_valid, i_sub, i_scale_a, i_scale_b, i_elements_a, i_elements_b, i_ready,
    input  o_ready, o_valid, o_scale, o_elements, o_overflow, o_nan
  );
endinterface

// File: rtl/mx_int_block_addsub_pipe_align_add.sv
// One element lane: align the smaller-scale operand, add or subtract, flag overflow.
// Purely combinational; the sum is one bit wider so nothing is lost before normalisation.
module mx_int_elem_align_add #(
  parameter int ELEM_WIDTH = 8,
  parameter int SHW        = $clog2(ELEM_WIDTH)
) (
  input  logic signed [ELEM_WIDTH-1:0] a,
  input  logic signed [ELEM_WIDTH-1:0] b,
  input  logic        [SHW-1:0]        shamt,
  input  logic                         shift_a,
  input  logic                         sub,
  output logic signed [ELEM_WIDTH:0]   sum,
  output logic                         ovf
);
  logic signed [ELEM_WIDTH-1:0] a_al;
  logic signed [ELEM_WIDTH-1:0] b_al;
  logic        [ELEM_WIDTH:0]   a_x;
  logic        [ELEM_WIDTH:0]   b_x;

  always_comb begin
    a_al = shift_a ? (a >>> shamt) : a;
    b_al = shift_a ? b : (b >>> shamt);
    a_x  = {a_al[ELEM_WIDTH-1], a_al};
    b_x  = {b_al[ELEM_WIDTH-1], b_al};
    sum  = sub ? signed'(a_x - b_x) : signed'(a_x + b_x);
    // Out of ELEM_WIDTH-bit range exactly when the top two bits disagree.
    ovf  = sum[ELEM_WIDTH] ^ sum[ELEM_WIDTH-1];
  end
endmodule

// File: rtl/mx_int_block_addsub_pipe.sv
// 3-stage MX integer block add/sub: compare scales, align+combine, renormalise with NaN handling.
// Latency 3, throughput 1/cycle; a single stall enable freezes all stages when the output is held.
module mx_int_block_addsub_pipe
  import mx_int_pkg::*;
#(
  parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
  parameter int ELEM_WIDTH  = DEF_ELEM_WIDTH,
  parameter int SCALE_WIDTH = DEF_SCALE_WIDTH
) (
  input logic                        clk,
  input logic                        rst,
  mx_int_block_addsub_pipe_if.slave  bus
);
  localparam int SHW = $clog2(ELEM_WIDTH);
  localparam logic [SCALE_WIDTH-1:0] SCALE_ALL_ONES = '1;
  localparam logic [SCALE_WIDTH-1:0] SCALE_PRE_NAN  = {{(SCALE_WIDTH-1){1'b1}}, 1'b0};

  logic en;
  assign en          = !bus.o_valid || bus.i_ready;
  assign bus.o_ready = en;

  stage_flags_t           s1_flags;
  logic [SCALE_WIDTH-1:0] s1_smax;
  logic [SCALE_WIDTH-1:0] s1_diff;
  logic                   s1_shift_a;
  logic [ELEM_WIDTH-1:0]  s1_a [BLOCK_SIZE];
  logic [ELEM_WIDTH-1:0]  s1_b [BLOCK_SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_flags   <= '0;
      s1_smax    <= '0;
      s1_diff    <= '0;
      s1_shift_a <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        s1_a[i] <= '0;
        s1_b[i] <= '0;
      end
    end else if (en) begin
      s1_flags.valid <= bus.i_valid;
      s1_flags.nan   <= (bus.i_scale_a == SCALE_ALL_ONES) || (bus.i_scale_b == SCALE_ALL_ONES);
      s1_flags.sub   <= bus.i_sub;
      s1_shift_a     <= bus.i_scale_a < bus.i_scale_b;
      s1_smax        <= (bus.i_scale_a < bus.i_scale_b) ? bus.i_scale_b : bus.i_scale_a;
      s1_diff        <= (bus.i_scale_a < bus.i_scale_b) ? (bus.i_scale_b - bus.i_scale_a)
                                                        : (bus.i_scale_a - bus.i_scale_b);
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        s1_a[i] <= bus.i_elements_a[i];
        s1_b[i] <= bus.i_elements_b[i];
      end
    end
  end

  // Shifting by ELEM_WIDTH-1 already collapses any element to 0 or -1.
  logic [SHW-1:0]        s1_shamt;
  logic [ELEM_WIDTH:0]   sum_w [BLOCK_SIZE];
  logic [BLOCK_SIZE-1:0] ovf_w;

  assign s1_shamt = SHW'(clamp_shift(int'(s1_diff), ELEM_WIDTH - 1));

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
    mx_int_elem_align_add #(.ELEM_WIDTH(ELEM_WIDTH), .SHW(SHW)) u_lane (
      .a       (s1_a[g]),
      .b       (s1_b[g]),
      .shamt   (s1_shamt),
      .shift_a (s1_shift_a),
      .sub     (s1_flags.sub),
      .sum     (sum_w[g]),
      .ovf     (ovf_w[g])
    );
  end

  stage_flags_t           s2_flags;
  logic [SCALE_WIDTH-1:0] s2_smax;
  logic                   s2_ovf;
  logic [ELEM_WIDTH:0]    s2_sum [BLOCK_SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_flags <= '0;
      s2_smax  <= '0;
      s2_ovf   <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) s2_sum[i] <= '0;
    end else if (en) begin
      s2_flags <= s1_flags;
      s2_smax  <= s1_smax;
      s2_ovf   <= |ovf_w;
      for (int i = 0; i < BLOCK_SIZE; i++) s2_sum[i] <= sum_w[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid    <= 1'b0;
      bus.o_scale    <= '0;
      bus.o_overflow <= 1'b0;
      bus.o_nan      <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) bus.o_elements[i] <= '0;
    end else if (en) begin
      bus.o_valid <= s2_flags.valid;
      // A renormalising bump from the largest finite scale would land on the NaN code.
      if (s2_flags.nan || (s2_ovf && (s2_smax == SCALE_PRE_NAN))) begin
        bus.o_scale    <= SCALE_ALL_ONES;
        bus.o_overflow <= 1'b0;
        bus.o_nan      <= 1'b1;
        for (int i = 0; i < BLOCK_SIZE; i++) bus.o_elements[i] <= '0;
      end else if (s2_ovf) begin
        bus.o_scale    <= s2_smax + SCALE_WIDTH'(1);
        bus.o_overflow <= 1'b1;
        bus.o_nan      <= 1'b0;
        for (int i = 0; i < BLOCK_SIZE; i++) bus.o_elements[i] <= s2_sum[i][ELEM_WIDTH:1];
      end else begin
        bus.o_scale    <= s2_smax;
        bus.o_overflow <= 1'b0;
        bus.o_nan      <= 1'b0;
        for (int i = 0; i < BLOCK_SIZE; i++) bus.o_elements[i] <= s2_sum[i][ELEM_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mx_int_block_addsub_pipe.sv
// Directed vector table plus backpressure and mid-stream reset sequences for the MX block adder.
module tb_mx_int_block_addsub_pipe;
  localparam int BS = 32;
  localparam int EW = 8;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mx_int_block_addsub_pipe_if #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW)) bus ();

  mx_int_block_addsub_pipe #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       sub;
    logic [7:0] sa, sb;
    logic [7:0] a0, b0, a1, b1, ar, br;
    logic [7:0] es, e0, e1, er;
    logic       eovf, enan;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sub, input logic [7:0] sa, input logic [7:0] sb,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input logic [7:0] ar, input logic [7:0] br);
    bus.i_sub     = sub;
    bus.i_scale_a = sa;
    bus.i_scale_b = sb;
    for (int i = 0; i < BS; i++) begin
      bus.i_elements_a[i] = (i == 0) ? a0 : (i == 1) ? a1 : ar;
      bus.i_elements_b[i] = (i == 0) ? b0 : (i == 1) ? b1 : br;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    drive(v.sub, v.sa, v.sb, v.a0, v.b0, v.a1, v.b1, v.ar, v.br);
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, 3);
    chk($sformatf("v%0d scale", idx), bus.o_scale, v.es);
    chk($sformatf("v%0d overflow", idx), bus.o_overflow, v.eovf);
    chk($sformatf("v%0d nan", idx), bus.o_nan, v.enan);
    for (int i = 0; i < BS; i++)
      chk($sformatf("v%0d elem%0d", idx, i), bus.o_elements[i],
          (i == 0) ? v.e0 : (i == 1) ? v.e1 : v.er);
  endtask

  initial begin
    int sent, got, extra, stale;
    logic fire_in, stalled, saw_low;
    logic [7:0] h_scale, h_e0, h_elast;

    //          sub   sa     sb     a0     b0     a1     b1     ar     br     es     e0     e1     er   ovf   nan
    vecs[0]  = '{1'b0, 8'd127, 8'd127, 8'h10, 8'h20, 8'h10, 8'h20, 8'h10, 8'h20, 8'd127, 8'h30, 8'h30, 8'h30, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd127, 8'd127, 8'h7F, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'd128, 8'h40, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'd130, 8'd127, 8'h08, 8'h40, 8'h08, 8'h40, 8'h08, 8'h40, 8'd130, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd127, 8'd100, 8'h10, 8'hFF, 8'h10, 8'hFF, 8'h10, 8'hFF, 8'd127, 8'h0F, 8'h0F, 8'h0F, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'd127, 8'd127, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'd128, 8'h80, 8'h80, 8'h80, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'hFF,  8'd127, 8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22, 8'hFF,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'd254, 8'd254, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'd254, 8'd254, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'd254, 8'h20, 8'h20, 8'h20, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'd127, 8'hFF,  8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22, 8'hFF,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'd100, 8'd102, 8'h40, 8'h10, 8'h40, 8'h10, 8'h40, 8'h10, 8'd102, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'd127, 8'd128, 8'hF9, 8'h00, 8'hF9, 8'h00, 8'hF9, 8'h00, 8'd128, 8'hFC, 8'hFC, 8'hFC, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'd0,   8'd0,   8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'd1,   8'h81, 8'h81, 8'h81, 1'b1, 1'b0};

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("reset o_valid", bus.o_valid, 0);
    chk("reset o_scale", bus.o_scale, 0);
    chk("reset o_overflow", bus.o_overflow, 0);
    chk("reset o_nan", bus.o_nan, 0);
    chk("reset o_elements[0]", bus.o_elements[0], 0);
    chk("reset o_ready", bus.o_ready, 1);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) run_vec(v, vecs[v]);

    // Five back-to-back transactions, downstream stalls for four cycles.
    sent = 0; got = 0; extra = 0;
    fire_in = 1'b0; stalled = 1'b0; saw_low = 1'b0;
    h_scale = '0; h_e0 = '0; h_elast = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (fire_in) sent++;
      if (stalled) begin
        chk("stall o_valid", bus.o_valid, 1);
        chk("stall o_scale", bus.o_scale, h_scale);
        chk("stall o_elements[0]", bus.o_elements[0], h_e0);
        chk("stall o_elements[last]", bus.o_elements[BS-1], h_elast);
      end
      bus.i_ready = !(cyc >= 3 && cyc < 7);
      if (sent < 5) begin
        drive(1'b0, 8'(10 + sent), 8'(10 + sent), 8'(sent + 1), 8'd1,
              8'(sent + 1), 8'd1, 8'(sent + 1), 8'd1);
        bus.i_valid = 1'b1;
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (!bus.o_ready) saw_low = 1'b1;
      fire_in = bus.i_valid && bus.o_ready;
      if (bus.o_valid && bus.i_ready) begin
        if (got < 5) begin
          chk($sformatf("bp order scale #%0d", got), bus.o_scale, 10 + got);
          chk($sformatf("bp elem0 #%0d", got), bus.o_elements[0], got + 2);
          chk($sformatf("bp elemlast #%0d", got), bus.o_elements[BS-1], got + 2);
        end else begin
          extra++;
        end
        got++;
      end
      stalled = bus.o_valid && !bus.i_ready;
      h_scale = bus.o_scale;
      h_e0    = bus.o_elements[0];
      h_elast = bus.o_elements[BS-1];
    end
    chk("bp o_ready fell", saw_low, 1);
    chk("bp outputs delivered", got, 5);
    chk("bp duplicates", extra, 0);
    bus.i_ready = 1'b1;

    // Reset with the pipeline full and a new transaction offered in the same cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 8'(50 + k), 8'(50 + k), 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
      bus.i_valid = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset o_valid", bus.o_valid, 0);
    chk("mid reset o_scale", bus.o_scale, 0);
    chk("mid reset o_elements[0]", bus.o_elements[0], 0);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_valid) stale++;
    end
    chk("post reset stale outputs", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
